serial_frame_rx: RTL
====================

// Module: serial_frame_rx
// PURPOSE
//  Receive end of the single-wire serial link. Recovers framed words from din: idle-high line,
//  one start bit (0), WIDTH data bits LSB first, one stop bit (1). Each bit lasts CLKS_PER_BIT clocks.
//  Delivers each word on dout with a valid/ready handshake and flags framing and overrun errors.
//  Sits behind the serial pin, feeding the parallel datapath.
// PARAMETERS
//  WIDTH         8  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clocks per bit period (>=2, even)
// PORTS
//  clk         input   1      single clock, all logic on posedge clk
//  reset       input   1      synchronous, active-high
//  din         input   1      serial line, asynchronous to clk, idle high
//  dout        output  WIDTH  received word, stable while dout_valid=1
//  dout_valid  output  1      word held on dout
//  dout_ready  input   1      consumer accepts word when dout_valid&&dout_ready
//  frame_err   output  1      one-cycle pulse: stop bit sampled 0
//  overrun     output  1      one-cycle pulse: completed word dropped, holding reg full
// BEHAVIOUR
//  Reset (when reset=1 at posedge clk):
//  - state=IDLE; cnt=0; bit_idx=0; shift=0.
//  - Sync flops=1; dout=0; dout_valid=0; frame_err=0; overrun=0.
//  - Reset mid-frame aborts the frame; any held word is discarded.
//  Input sampling:
//  - din passes two flops (din_s); 2-cycle latency.
//  - FSM sees only din_s.
//  FSM (HALF=CLKS_PER_BIT/2):
//  - IDLE:  din_s=0 -> START, cnt=0.
//  - START: cnt increments. At cnt=HALF-1:
//           din_s=0 -> DATA, cnt=0, bit_idx=0.
//           din_s=1 -> IDLE; glitch, no flags.
//  - DATA:  at cnt=CLKS_PER_BIT-1: shift[bit_idx]<=din_s, cnt=0, bit_idx++.
//           After bit WIDTH-1 -> STOP.
//           Sample points are mid-bit.
//  - STOP:  at cnt=CLKS_PER_BIT-1:
//           din_s=1 -> word complete, -> IDLE.
//           din_s=0 -> frame_err=1 for one cycle, word discarded, -> IDLE.
//           Next start bit is accepted from the following cycle.
//  Handshake / holding register:
//  - Word complete and dout_valid=0: dout<=shift, dout_valid<=1 next cycle.
//  - dout_valid&&dout_ready: dout_valid<=0 unless a word completes the same cycle.
//  - Word complete while dout_valid=1 && dout_ready=0:
//           overrun=1 for one cycle; dout keeps the old word; new word dropped.
//  - Word complete while dout_valid=1 && dout_ready=1:
//           new word loaded, dout_valid stays 1, no overrun.
//  - dout/dout_valid never change while dout_valid=1 && dout_ready=0,
//    except on reset.
//  - frame_err and overrun never assert together; both are 0 outside their pulse.
//  Widths and timing:
//  - cnt is $clog2(CLKS_PER_BIT) bits; bit_idx is $clog2(WIDTH+1) bits.
//  - No wrap beyond terminal counts.
//  - Line-to-dout latency: stop mid-bit sample + 2 sync + 1 register cycle.
// STRUCTURE
//  Shared package:
//  - State encoding localparams: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
//  - LINE_IDLE=1'b1.
//  Sub-module sync_2ff:
//  - Two-flop synchronizer, reset value 1.
//  - Reused by other pin inputs.
//  FSM, counters and holding register stay in this module.
// TESTING (WIDTH=8, CLKS_PER_BIT=4)
//  1. Send 0xA5 framed, dout_ready=1 -> one dout_valid cycle with dout=8'hA5.
//     frame_err=0, overrun=0.
//  2. din low for 1 clk only -> FSM returns to IDLE.
//     No dout_valid, no frame_err.
//  3. Send 0x3C with stop bit 0 -> one-cycle frame_err.
//     dout_valid stays 0; next good frame 0x11 received correctly.
//  4. dout_ready=0, send 0x01 then 0x02 back-to-back -> dout=8'h01 held, dout_valid=1.
//     Single overrun pulse at 0x02 completion.
//  5. dout_valid=1 (0x55), raise dout_ready in the cycle 0xAA completes -> dout=8'hAA.
//     dout_valid stays 1, no overrun.
//  6. Assert reset during DATA bit 4 of 0xFF -> all outputs 0 next cycle.
//     Subsequent 0x80 frame received correctly.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// rtl/serial_frame_rx_pkg.sv - shared types and constants for the serial frame receiver
//
// Purpose: receiver FSM state encoding and the line idle level.
// Ports:   none (package).
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level of the serial line when nothing is being sent; also the stop-bit level.
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial pin plus parallel word handshake of the receiver
//
// Purpose: bundles the serial input line and the word output handshake.
// Signals: din        serial line, idle high
//          dout       received word, stable while dout_valid=1
//          dout_valid word held on dout
//          dout_ready consumer accepts when dout_valid && dout_ready
//          frame_err  one-cycle pulse, stop bit sampled low
//          overrun    one-cycle pulse, completed word dropped
// Modports: master = receiver side, slave = line driver / word consumer side.
interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);

  logic             din;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    input  din,
    input  dout_ready,
    output dout,
    output dout_valid,
    output frame_err,
    output overrun
  );

  modport slave (
    output din,
    output dout_ready,
    input  dout,
    input  dout_valid,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous pin inputs
//
// Purpose: brings an asynchronous single-bit input into the clk domain.
// Ports:   clk    clock
//          reset  synchronous, active-high; both flops load RESET_VAL
//          d      asynchronous input
//          q      synchronized output, two clocks of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial frame receiver with word handshake and error flags
//
// Purpose: recovers start/WIDTH data (LSB first)/stop framed words from an idle-high
//          line with CLKS_PER_BIT clocks per bit, presents them on a valid/ready
//          holding register and pulses frame_err / overrun.
// Ports:   clk    clock, all logic on posedge
//          reset  synchronous, active-high; aborts any frame and drops a held word
//          bus    serial_frame_rx_if.master (din, dout, dout_valid, dout_ready,
//                 frame_err, overrun)
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_rx_if.master  bus
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  logic             din_s;

  state_t           state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shift_q,   shift_d;

  logic [WIDTH-1:0] dout_q,    dout_d;
  logic             valid_q,   valid_d;
  logic             ferr_q,    ferr_d;
  logic             ovr_q,     ovr_d;

  logic             word_done;
  logic             stop_bad;

  sync_2ff #(
    .RESET_VAL (LINE_IDLE)
  ) u_din_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.din),
    .q     (din_s)
  );

  // Bit timing: the start bit is confirmed half a bit after its falling edge,
  // so every later sample (one full bit period apart) lands mid-bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    word_done = 1'b0;
    stop_bad  = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_s != LINE_IDLE) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          if (din_s != LINE_IDLE) begin
            state_d   = DATA;
            cnt_d     = '0;
            bit_idx_d = '0;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_idx_q == IDX_W'(i)) begin
              shift_d[i] = din_s;
            end
          end
          cnt_d     = '0;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          if (din_s == LINE_IDLE) begin
            word_done = 1'b1;
          end else begin
            stop_bad = 1'b1;
          end
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Holding register: a completed word is taken if the register is empty or
  // being emptied this same cycle; otherwise the new word is dropped.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;

    if (valid_q && bus.dout_ready) begin
      valid_d = 1'b0;
    end

    if (word_done) begin
      if (!valid_q || bus.dout_ready) begin
        dout_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule
